// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue front end for a fixed-latency pipelined multiplier.
// Requests go straight to the multiplier. A shadow queue follows each op
// through the pipe so its result can be steered into a small output FIFO.
// The multiplier cannot stall, so issue is gated by output FIFO credits.
module mult_issue_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned MULT_STAGES = 4,
  parameter int unsigned OUT_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_func,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              mult_start,
  output logic [1:0]        mult_mode,
  output logic [XLEN-1:0]   mult_mcand,
  output logic [XLEN-1:0]   mult_mplier,
  input  logic [2*XLEN-1:0] mult_product,
  input  logic              mult_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              err_unexp_done
);

  localparam int unsigned SqPw = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;
  localparam int unsigned SqCw = $clog2(MULT_STAGES + 1);
  localparam int unsigned OfPw = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned OfCw = $clog2(OUT_DEPTH + 1);
  localparam int unsigned CrW  = $clog2(MULT_STAGES + OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    FnMul    = 2'b00,
    FnMulh   = 2'b01,
    FnMulhsu = 2'b10,
    FnMulhu  = 2'b11
  } func_e;

  // Shadow queue: one entry per op inside the multiplier.
  logic [TAG_W-1:0]       sq_tag_q [MULT_STAGES];
  logic [MULT_STAGES-1:0] sq_hi_q;
  logic [MULT_STAGES-1:0] sq_killed_q, sq_killed_d;
  logic [SqPw-1:0]        sq_wr_q, sq_wr_d, sq_rd_q, sq_rd_d;
  logic [SqCw-1:0]        in_flight_q, in_flight_d;

  // Output FIFO.
  logic [XLEN-1:0]        of_data_q [OUT_DEPTH];
  logic [TAG_W-1:0]       of_tag_q [OUT_DEPTH];
  logic [OfPw-1:0]        of_wr_q, of_wr_d, of_rd_q, of_rd_d;
  logic [OfCw-1:0]        out_count_q, out_count_d;

  logic                   err_q, err_d;

  logic                   accept;
  logic                   sq_pop;
  logic                   unexp;
  logic                   head_killed;
  logic [XLEN-1:0]        res_word;
  logic                   of_wr;
  logic                   of_pop;
  logic [CrW-1:0]         credits_used;

  function automatic logic [SqPw-1:0] sq_inc(input logic [SqPw-1:0] p);
    return (p == SqPw'(MULT_STAGES - 1)) ? '0 : p + SqPw'(1);
  endfunction

  function automatic logic [OfPw-1:0] of_inc(input logic [OfPw-1:0] p);
    return (p == OfPw'(OUT_DEPTH - 1)) ? '0 : p + OfPw'(1);
  endfunction

  // Every op in the multiplier or the FIFO holds one credit; a same-cycle pop
  // only frees its credit once the registered count drops.
  assign credits_used = CrW'(in_flight_q) + CrW'(out_count_q);
  assign req_ready    = !reset && !flush && (credits_used < CrW'(OUT_DEPTH));
  assign accept       = req_valid && req_ready;

  assign mult_start   = accept;
  assign mult_mcand   = req_rs1;
  assign mult_mplier  = req_rs2;

  // Remap RISC-V funct to the multiplier's signedness mode.
  always_comb begin
    mult_mode = 2'b00;
    case (func_e'(req_func))
      FnMul:    mult_mode = 2'b00;
      FnMulh:   mult_mode = 2'b01;
      FnMulhsu: mult_mode = 2'b11;
      FnMulhu:  mult_mode = 2'b10;
      default:  mult_mode = 2'b00;
    endcase
  end

  assign sq_pop      = mult_done && (in_flight_q != '0);
  assign unexp       = mult_done && (in_flight_q == '0);
  assign head_killed = sq_killed_q[sq_rd_q];
  assign res_word    = sq_hi_q[sq_rd_q] ? mult_product[2*XLEN-1:XLEN] : mult_product[XLEN-1:0];
  // A completion landing in the flush cycle is dropped along with the FIFO.
  assign of_wr       = sq_pop && !head_killed && !flush;
  assign of_pop      = (out_count_q != '0) && rsp_ready;

  // Shadow queue next state: pointers, occupancy and kill marks.
  always_comb begin
    sq_wr_d     = sq_wr_q;
    sq_rd_d     = sq_rd_q;
    in_flight_d = in_flight_q;
    sq_killed_d = sq_killed_q;
    if (accept) begin
      sq_wr_d              = sq_inc(sq_wr_q);
      sq_killed_d[sq_wr_q] = 1'b0;
    end
    if (sq_pop) begin
      sq_rd_d = sq_inc(sq_rd_q);
    end
    if (accept && !sq_pop) begin
      in_flight_d = in_flight_q + SqCw'(1);
    end else if (!accept && sq_pop) begin
      in_flight_d = in_flight_q - SqCw'(1);
    end
    // Killed ops still drain through the multiplier and keep their credit.
    if (flush) begin
      sq_killed_d = '1;
    end
  end

  // Output FIFO next state; flush empties it on the following cycle.
  always_comb begin
    of_wr_d     = of_wr_q;
    of_rd_d     = of_rd_q;
    out_count_d = out_count_q;
    if (flush) begin
      of_wr_d     = '0;
      of_rd_d     = '0;
      out_count_d = '0;
    end else begin
      if (of_wr) begin
        of_wr_d = of_inc(of_wr_q);
      end
      if (of_pop) begin
        of_rd_d = of_inc(of_rd_q);
      end
      if (of_wr && !of_pop) begin
        out_count_d = out_count_q + OfCw'(1);
      end else if (!of_wr && of_pop) begin
        out_count_d = out_count_q - OfCw'(1);
      end
    end
  end

  assign err_d = err_q || unexp;

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sq_wr_q     <= '0;
      sq_rd_q     <= '0;
      in_flight_q <= '0;
      sq_killed_q <= '0;
      of_wr_q     <= '0;
      of_rd_q     <= '0;
      out_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      sq_wr_q     <= sq_wr_d;
      sq_rd_q     <= sq_rd_d;
      in_flight_q <= in_flight_d;
      sq_killed_q <= sq_killed_d;
      of_wr_q     <= of_wr_d;
      of_rd_q     <= of_rd_d;
      out_count_q <= out_count_d;
      err_q       <= err_d;
    end
  end

  // Payload storage; validity is tracked by the pointers above.
  always_ff @(posedge clock) begin
    if (accept) begin
      sq_tag_q[sq_wr_q] <= req_tag;
      sq_hi_q[sq_wr_q]  <= (func_e'(req_func) != FnMul);
    end
    if (of_wr) begin
      of_data_q[of_wr_q] <= res_word;
      of_tag_q[of_wr_q]  <= sq_tag_q[sq_rd_q];
    end
  end

  assign rsp_valid      = !reset && (out_count_q != '0);
  assign rsp_data       = of_data_q[of_rd_q];
  assign rsp_tag        = of_tag_q[of_rd_q];
  assign err_unexp_done = err_q;

  // Credit accounting must make these unreachable.
  a_no_of_overflow : assert property (@(posedge clock) disable iff (reset)
    !(of_wr && (out_count_q == OfCw'(OUT_DEPTH))));
  a_no_sq_overflow : assert property (@(posedge clock) disable iff (reset)
    !(accept && !sq_pop && (in_flight_q == SqCw'(MULT_STAGES))));

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Front-end controller for the 4-stage pipelined 32x32 multiplier (`mult`).
- Accepts RISC-V M-extension multiply requests (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake and drives the multiplier's start, mode and operand inputs.
- Tracks each in-flight operation's tag and function through the fixed-latency pipeline, selects the low or high product word, and buffers results in an output FIFO.
- The multiplier cannot stall, so issue is credit-gated against free output-buffer space.

Parameters:
- XLEN, 32, operand/result width; the product is 2*XLEN.
- TAG_W, 5, width of the request tag (e.g. ROB index).
- MULT_STAGES, 4, multiplier latency in cycles from start to done.
- OUT_DEPTH, 4, output FIFO entries; also the total credit limit.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_rs1  in  XLEN  multiplicand
- req_rs2  in  XLEN  multiplier
- req_tag  in  TAG_W  request tag
- flush  in  1  squash all outstanding work
- mult_start  out  1  start pulse to the multiplier
- mult_mode  out  2  multiplier mode
- mult_mcand  out  XLEN  operand to the multiplier
- mult_mplier  out  XLEN  operand to the multiplier
- mult_product  in  2*XLEN  multiplier product
- mult_done  in  1  multiplier completion
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  XLEN  selected result word
- rsp_tag  out  TAG_W  tag of the result
- err_unexp_done  out  1  sticky: mult_done seen with no op in flight

Behaviour:
- Reset (synchronous): in-flight queue empty, output FIFO empty, in_flight=0, err_unexp_done=0.
  - Outputs during reset: rsp_valid=0, mult_start=0, req_ready=0.
  - Reset mid-operation discards everything. The multiplier shares the reset, so there are no stale completions.
- Credit rule: req_ready = !reset && !flush && (in_flight + out_count < OUT_DEPTH).
  - A same-cycle rsp pop does not free a credit until the next cycle.
- Issue: accept = req_valid && req_ready. mult_start = accept, combinational.
  - mult_mcand = req_rs1 and mult_mplier = req_rs2, combinational pass-through.
  - mult_mode mapping: MUL->00, MULH->01, MULHSU->11, MULHU->10.
  - Operands and mode are don't-care when mult_start=0.
- Shadow queue: in-order FIFO of depth MULT_STAGES holding {tag, hi_sel, killed}.
  - hi_sel=0 only for MUL.
  - Push on accept; pop on mult_done.
  - in_flight counts queue occupancy. It never exceeds MULT_STAGES, since one issue per cycle is allowed and latency is fixed.
- Completion: on mult_done with the queue non-empty, pop the head.
  - If the head is not killed, write {head.tag, hi_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0]} into the output FIFO.
  - A simultaneous push and pop leaves in_flight unchanged.
- mult_done with an empty queue: set err_unexp_done (sticky until reset) and ignore the product.
- Latency: accept in cycle 0 gives mult_done in cycle MULT_STAGES and rsp_valid in cycle MULT_STAGES+1, so 5 cycles at defaults.
  - Throughput is 1 result/cycle with rsp_ready held high.
- Output FIFO:
  - rsp_valid = !empty; rsp_data and rsp_tag are taken from the head.
  - Pop on rsp_valid && rsp_ready. Simultaneous write and pop is allowed.
  - Read and write pointers wrap modulo OUT_DEPTH.
  - The credit rule guarantees no write when full. A write while full is an assertion failure.
- Flush (single cycle):
  - Output FIFO cleared next cycle.
  - Every shadow entry's killed bit is set, including any entry being pushed that cycle. No accept occurs, since req_ready=0.
  - Killed entries still pop on mult_done and hold credit until then, so issue resumes immediately but stays credit-limited.
  - A completion in the flush cycle is dropped.
- rsp_data and rsp_tag must remain stable while rsp_valid && !rsp_ready.

Test Plan:
- MUL 7 x 6, tag 3, rsp_ready=1 -> rsp_valid in cycle 5 with rsp_data=0x0000002A, rsp_tag=3; mult_mode=00 observed.
- Back-to-back MULH 0xFFFFFFFF x 0xFFFFFFFF, MULHU 0xFFFFFFFF x 0xFFFFFFFF, MULHSU 0xFFFFFFFF x 0x00000002, tags 1,2,3 -> in-order results 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF on consecutive cycles 5,6,7.
- rsp_ready=0, req_valid held with 6 requests -> exactly 4 accepted, then req_ready=0. Raising rsp_ready drains tags in order; req_ready returns one cycle after the first pop.
- Issue 3 ops, assert flush 2 cycles later -> no rsp_valid from those ops. err_unexp_done stays 0. A request issued right after flush returns correctly with its own tag.
- Assert reset while 3 ops are in flight and 2 results are buffered -> next cycle rsp_valid=0, req_ready=0 during reset, no stale responses afterwards.
- Force mult_done=1 with nothing issued -> err_unexp_done=1 and stays set until reset; no rsp_valid.
